// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: sequencer state codes, opcodes and the HALT code.
// The ALU imports S_EXECUTE from here so both blocks agree on the evaluate cycle.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  localparam logic [5:0] HALT_CODE_DEFAULT = 6'h3F;

  function automatic logic [1:0] opcode_of(input logic [7:0] ir);
    return ir[7:6];
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational strobe decode for the instruction sequencer.
// Outputs depend only on the registered state and latched instruction.
module seq_decode
  import cpu_pkg::*;
#(
  parameter logic [5:0] HALT_CODE = HALT_CODE_DEFAULT
) (
  input  state_t     state,
  input  logic [7:0] ir,
  output logic       alu_op,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write,
  output logic       branch
);

  logic [1:0] op;
  logic       is_halt;

  assign op      = opcode_of(ir);
  assign is_halt = (op == OP_JUMP) && (ir[5:0] == HALT_CODE);

  always_comb begin
    alu_op    = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    case (state)
      S_EXECUTE: begin
        alu_op = (op != OP_JUMP);
        if (op == OP_JUMP && !is_halt) begin
          pc_write = 1'b1;
          branch   = 1'b1;
        end
      end
      S_MEMORY: begin
        // STORE retires here; PCWrite cannot look at MemReady, so it is held with the strobe.
        if (op == OP_LOAD) begin
          mem_read = 1'b1;
        end else if (op == OP_STORE) begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
        end
      end
      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: latches instructions, sequences them, counts retirements.
// Optional single-step mode is enabled with the INSTR_SEQUENCER_SINGLE_STEP_EN macro.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int         CNT_W     = 8,
  parameter logic [5:0] HALT_CODE = HALT_CODE_DEFAULT
) (
  input  logic             clk,
  input  logic             Clear_n,
  input  logic             Run,
  input  logic [7:0]       Instr,
  input  logic             MemReady,
  input  logic             Step,
  output logic [2:0]       state,
  output logic [7:0]       IR,
  output logic             ALUOp,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  state_t           state_q, state_d, retire_state;
  logic [7:0]       ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             go;
  logic [1:0]       op;

  assign op = opcode_of(ir_q);

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) step_q <= 1'b0;
    else          step_q <= Step;
  end

  assign go           = Run & Step & ~step_q;
  assign retire_state = S_IDLE;
`else
  logic unused_step;

  assign unused_step  = Step;
  assign go           = Run;
  assign retire_state = Run ? S_FETCH : S_IDLE;
`endif

  // Memory handshake: MEMORY holds with its strobe asserted while MemReady=0 and
  // leaves on the first clock that samples MemReady=1; MemReady is ignored elsewhere.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:    if (go) state_d = S_FETCH;
      S_FETCH:   state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (op)
          OP_ADD:   state_d = S_WRITEBACK;
          OP_LOAD:  state_d = S_MEMORY;
          OP_STORE: state_d = S_MEMORY;
          default: begin
            if (ir_q[5:0] == HALT_CODE) state_d = S_HALT;
            else                        retire  = 1'b1;
          end
        endcase
      end
      S_MEMORY: begin
        if (MemReady) begin
          if (op == OP_LOAD) state_d = S_WRITEBACK;
          else               retire  = 1'b1;
        end
      end
      S_WRITEBACK: retire = 1'b1;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
    if (retire) state_d = retire_state;
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= S_IDLE;
      ir_q    <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) ir_q <= Instr;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  seq_decode #(.HALT_CODE(HALT_CODE)) u_decode (
    .state     (state_q),
    .ir        (ir_q),
    .alu_op    (ALUOp),
    .reg_write (RegWrite),
    .mem_read  (MemRead),
    .mem_write (MemWrite),
    .pc_write  (PCWrite),
    .branch    (Branch)
  );

  assign state      = state_q;
  assign IR         = ir_q;
  assign Halted     = (state_q == S_HALT);
  assign InstrCount = cnt_q;

endmodule
